// File: rtl/cpu_load_pkg.sv
// Shared load-path types: selector codes, fault causes and fetch-unit states.
// Used by the load fetch unit, the load extender and the control unit.
package cpu_load_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        SEL_LD      = 3'd0,
        SEL_LW      = 3'd1,
        SEL_LH      = 3'd2,
        SEL_LB      = 3'd3,
        SEL_LWU     = 3'd4,
        SEL_LHU     = 3'd5,
        SEL_LBU     = 3'd6,
        SEL_ILLEGAL = 3'd7
    } load_sel_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_ILLEGAL  = 2'b11
    } fault_cause_t;

    typedef enum logic [1:0] {
        LFU_IDLE = 2'd0,
        LFU_REQ  = 2'd1,
        LFU_WAIT = 2'd2,
        LFU_RESP = 2'd3
    } lfu_state_t;

    function automatic logic is_illegal_sel(input logic [2:0] sel);
        return sel == SEL_ILLEGAL;
    endfunction

endpackage

// File: rtl/load_fetch_unit_if.sv
// Request, memory and result signals of the load fetch unit.
// The unit itself is the slave; the surrounding pipeline/memory side is the master.
interface load_fetch_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [2:0]  req_sel;

    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    logic        ld_valid;
    logic [63:0] ld_data;
    logic [2:0]  ld_sel;
    logic        ld_fault;
    logic [1:0]  fault_cause;

    modport slave (
        input  req_valid, req_addr, req_sel, mem_rdata, mem_ack,
        output req_ready, mem_rd, mem_addr, ld_valid, ld_data, ld_sel, ld_fault, fault_cause
    );

    modport master (
        output req_valid, req_addr, req_sel, mem_rdata, mem_ack,
        input  req_ready, mem_rd, mem_addr, ld_valid, ld_data, ld_sel, ld_fault, fault_cause
    );

endinterface

// File: rtl/load_align_shifter.sv
// Combinational offset alignment, misalignment detection and right-justifying shift.
// MISALIGN_TRAP_EN selects trapping misaligned loads instead of forcing natural alignment.
module load_align_shifter
    import cpu_load_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr_lo,
    input  logic [2:0]      sel,
    output logic [2:0]      off,
    output logic            misalign,
    output logic [XLEN-1:0] data
);

    always_comb begin
        off      = addr_lo;
        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (sel)
            SEL_LD:          misalign = (addr_lo != 3'd0);
            SEL_LW, SEL_LWU: misalign = (addr_lo[1:0] != 2'd0);
            SEL_LH, SEL_LHU: misalign = addr_lo[0];
            default:         misalign = 1'b0;
        endcase
`else
        // Without trapping, drop the low offset bits so the access is naturally aligned.
        case (sel)
            SEL_LD:          off = 3'd0;
            SEL_LW, SEL_LWU: off = {addr_lo[2], 2'b00};
            SEL_LH, SEL_LHU: off = {addr_lo[2:1], 1'b0};
            default:         off = addr_lo;
        endcase
`endif
        data = rdata >> {off, 3'b000};
    end

endmodule

// File: rtl/load_fetch_unit.sv
// Sequences one data-memory read per load and returns right-justified bytes plus selector.
// Define MISALIGN_TRAP_EN to fault misaligned loads (cause 01) instead of aligning them.
module load_fetch_unit
    import cpu_load_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    load_fetch_unit_if.slave bus
);

    lfu_state_t   state_q, state_d;
    logic [63:3]  line_q, line_d;
    logic [2:0]   off_q, off_d;
    logic [2:0]   sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [2:0]   ld_sel_q, ld_sel_d;
    logic         fault_q, fault_d;
    fault_cause_t cause_q, cause_d;

    logic [2:0]      shift_addr_lo;
    logic [2:0]      shift_sel;
    logic [2:0]      shift_off;
    logic            shift_mis;
    logic [XLEN-1:0] shift_data;

    // In IDLE the shifter checks the incoming request; afterwards it shifts with the captured offset.
    assign shift_addr_lo = (state_q == LFU_IDLE) ? bus.req_addr[2:0] : off_q;
    assign shift_sel     = (state_q == LFU_IDLE) ? bus.req_sel       : sel_q;

    load_align_shifter u_shifter (
        .rdata    (bus.mem_rdata),
        .addr_lo  (shift_addr_lo),
        .sel      (shift_sel),
        .off      (shift_off),
        .misalign (shift_mis),
        .data     (shift_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LFU_IDLE;
            line_q   <= '0;
            off_q    <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            ld_sel_q <= '0;
            fault_q  <= 1'b0;
            cause_q  <= FAULT_NONE;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            off_q    <= off_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            ld_sel_q <= ld_sel_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        off_d    = off_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ld_sel_d = ld_sel_q;
        fault_d  = fault_q;
        cause_d  = cause_q;
        case (state_q)
            LFU_IDLE: begin
                if (bus.req_valid) begin
                    line_d = bus.req_addr[63:3];
                    off_d  = shift_off;
                    sel_d  = bus.req_sel;
                    if (is_illegal_sel(bus.req_sel)) begin
                        state_d  = LFU_RESP;
                        ld_sel_d = bus.req_sel;
                        fault_d  = 1'b1;
                        cause_d  = FAULT_ILLEGAL;
                        data_d   = '0;
                    end else if (shift_mis) begin
                        state_d  = LFU_RESP;
                        ld_sel_d = bus.req_sel;
                        fault_d  = 1'b1;
                        cause_d  = FAULT_MISALIGN;
                        data_d   = '0;
                    end else begin
                        state_d = LFU_REQ;
                    end
                end
            end
            LFU_REQ: begin
                cnt_d   = '0;
                state_d = LFU_WAIT;
            end
            LFU_WAIT: begin
                // An ack on the final wait cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    state_d  = LFU_RESP;
                    ld_sel_d = sel_q;
                    fault_d  = 1'b0;
                    cause_d  = FAULT_NONE;
                    data_d   = shift_data;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = LFU_RESP;
                    ld_sel_d = sel_q;
                    fault_d  = 1'b1;
                    cause_d  = FAULT_TIMEOUT;
                    data_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LFU_RESP: begin
                state_d = LFU_IDLE;
            end
            default: begin
                state_d = LFU_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = (state_q == LFU_IDLE);
    assign bus.mem_rd      = (state_q == LFU_REQ);
    assign bus.mem_addr    = {line_q, 3'b000};
    assign bus.ld_valid    = (state_q == LFU_RESP);
    assign bus.ld_data     = data_q;
    assign bus.ld_sel      = ld_sel_q;
    assign bus.ld_fault    = (state_q == LFU_RESP) && fault_q;
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_load_fetch_unit.sv
// Directed scoreboard bench for load_fetch_unit; honours MISALIGN_TRAP_EN when defined.
module tb_load_fetch_unit;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  sel;
        logic        fault;
        logic [1:0]  cause;
        logic        mem;
        logic        check_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   rd_count = 0;
    exp_t sb[$];

    load_fetch_unit_if bus ();

    load_fetch_unit #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference behaviour of a request, independent of how the unit is built.
    function automatic exp_t model(input logic [63:0] addr, input logic [2:0] sel, input logic [63:0] rdata);
        exp_t e;
        int   off;
        logic mis;
        off = int'(addr[2:0]);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (sel == 3'd0) mis = (off != 0);
        if (sel == 3'd1 || sel == 3'd4) mis = (off % 4 != 0);
        if (sel == 3'd2 || sel == 3'd5) mis = (off % 2 != 0);
`else
        if (sel == 3'd0) off = 0;
        if (sel == 3'd1 || sel == 3'd4) off = off - (off % 4);
        if (sel == 3'd2 || sel == 3'd5) off = off - (off % 2);
`endif
        e.sel        = sel;
        e.data       = rdata >> (off * 8);
        e.fault      = 1'b0;
        e.cause      = 2'b00;
        e.mem        = 1'b1;
        e.check_data = 1'b1;
        if (sel == 3'd7) begin
            e.fault = 1'b1; e.cause = 2'b11; e.mem = 1'b0; e.check_data = 1'b0;
        end else if (mis) begin
            e.fault = 1'b1; e.cause = 2'b01; e.mem = 1'b0; e.check_data = 1'b0;
        end
        return e;
    endfunction

    // ack_wait: WAIT cycle (1-based) carrying mem_ack; 0 = never; > TIMEOUT = late ack after timeout.
    task automatic apply_stimulus(input logic [63:0] addr, input logic [2:0] sel, input logic [63:0] rdata,
                                  input int ack_wait, input string tag);
        exp_t e;
        int   rd_before;
        int   guard;
        e = model(addr, sel, rdata);
        if (e.mem && (ack_wait == 0 || ack_wait > TIMEOUT)) begin
            e.fault = 1'b1; e.cause = 2'b10; e.data = '0;
        end
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_output({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        sb.push_back(e);
        rd_before     = rd_count;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_sel   = sel;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (e.mem) begin
            check_output({tag, "_mem_rd"}, 64'(bus.mem_rd), 64'd1);
            check_output({tag, "_mem_addr"}, bus.mem_addr, {addr[63:3], 3'b000});
            check_output({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
            @(posedge clk); #1;
            for (int w = 1; w <= TIMEOUT; w++) begin
                check_output({tag, "_wait_rd"}, 64'(bus.mem_rd), 64'd0);
                check_output({tag, "_wait_valid"}, 64'(bus.ld_valid), 64'd0);
                bus.mem_ack   = (w == ack_wait);
                bus.mem_rdata = rdata;
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
                if (w == ack_wait) break;
            end
        end
        check_output({tag, "_resp_valid"}, 64'(bus.ld_valid), 64'd1);
        check_output({tag, "_resp_rd"}, 64'(bus.mem_rd), 64'd0);
        bus.mem_rdata = rdata;
        if (ack_wait > TIMEOUT) bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        check_output({tag, "_after_valid"}, 64'(bus.ld_valid), 64'd0);
        check_output({tag, "_after_ready"}, 64'(bus.req_ready), 64'd1);
        check_output({tag, "_rd_pulses"}, 64'(rd_count - rd_before), e.mem ? 64'd1 : 64'd0);
    endtask

    // Result monitor: pops the scoreboard on every ld_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (bus.mem_rd === 1'b1) rd_count++;
            if (bus.ld_valid === 1'b1) begin
                check_output("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_output("ld_sel", 64'(bus.ld_sel), 64'(e.sel));
                    check_output("ld_fault", 64'(bus.ld_fault), 64'(e.fault));
                    check_output("fault_cause", 64'(bus.fault_cause), 64'(e.cause));
                    if (e.check_data) check_output("ld_data", bus.ld_data, e.data);
                end
            end else begin
                check_output("ld_fault_idle", 64'(bus.ld_fault), 64'd0);
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_sel   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        #2;
        check_output("rst_ready", 64'(bus.req_ready), 64'd1);
        check_output("rst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check_output("rst_ld_valid", 64'(bus.ld_valid), 64'd0);
        check_output("rst_ld_data", bus.ld_data, 64'd0);
        check_output("rst_cause", 64'(bus.fault_cause), 64'd0);
        check_output("rst_mem_addr", bus.mem_addr, 64'd0);
        #10;
        reset_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] LB with ack two cycles after mem_rd");
        apply_stimulus(64'h1003, 3'd3, 64'h8877665544332211, 2, "lb");
        check_output("lb_byte", 64'(bus.ld_data[7:0]), 64'h44);

        $display("[TB] LD with ack in first WAIT cycle");
        apply_stimulus(64'h2000, 3'd0, 64'hDEADBEEFCAFEF00D, 1, "ld");
        check_output("ld_full", bus.ld_data, 64'hDEADBEEFCAFEF00D);

        $display("[TB] illegal selector");
        apply_stimulus(64'h2468, 3'd7, 64'h0, 1, "illegal");
        check_output("illegal_cause", 64'(bus.fault_cause), 64'd3);

        $display("[TB] LW at offset 6");
        apply_stimulus(64'h2006, 3'd1, 64'h1122334455667788, 1, "lw6");
`ifdef MISALIGN_TRAP_EN
        check_output("lw6_cause", 64'(bus.fault_cause), 64'd1);
`else
        check_output("lw6_word", 64'(bus.ld_data[31:0]), 64'h11223344);
`endif

        $display("[TB] assorted selectors and offsets");
        apply_stimulus(64'h4005, 3'd5, 64'h0F1E2D3C4B5A6978, 3, "lhu5");
        apply_stimulus(64'h4007, 3'd6, 64'hAB00000000000000, 1, "lbu7");
        apply_stimulus(64'h4004, 3'd4, 64'h89ABCDEF01234567, 4, "lwu4");

        $display("[TB] timeout handling");
        apply_stimulus(64'h3000, 3'd0, 64'h5555AAAA5555AAAA, 0, "tmo");
        check_output("tmo_data", bus.ld_data, 64'd0);
        apply_stimulus(64'h3008, 3'd0, 64'h1234567812345678, TIMEOUT + 1, "late");
        apply_stimulus(64'h3010, 3'd0, 64'h0BADC0DE0BADC0DE, TIMEOUT, "edge16");
        check_output("edge16_cause", 64'(bus.fault_cause), 64'd0);

        $display("[TB] reset during WAIT");
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h6000;
        bus.req_sel   = 3'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("wait_busy", 64'(bus.req_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check_output("arst_mem_rd", 64'(bus.mem_rd), 64'd0);
        check_output("arst_ld_valid", 64'(bus.ld_valid), 64'd0);
        check_output("arst_ready", 64'(bus.req_ready), 64'd1);
        check_output("arst_ld_data", bus.ld_data, 64'd0);
        @(posedge clk); #1;
        reset_n       = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("stale_ack_valid", 64'(bus.ld_valid), 64'd0);
            @(posedge clk); #1;
        end
        apply_stimulus(64'h5002, 3'd2, 64'hA1B2C3D4E5F60718, 3, "lh");
        check_output("lh_half", 64'(bus.ld_data[15:0]), 64'hE5F6);

        check_output("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
